// File: rtl/cache_fill_fsm.sv
// Miss-handling controller: stalls the pipeline, streams one cache block from
// main memory into the data array, then pulses the tag write.
module cache_fill_fsm #(
  parameter int WORDS = 8,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_detected,
  input  logic [AW-1:0]            miss_address,
  input  logic                     memory_data_valid,
  input  logic [DW-1:0]            memory_data,
  output logic                     fsm_busy,
  output logic                     mem_read_en,
  output logic [AW-1:0]            memory_address,
  output logic                     write_data_array,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic [DW-1:0]            fill_data,
  output logic                     write_tag_array,
  output logic [AW-1:0]            fill_block_addr
);

  localparam int LW = $clog2(WORDS);
  localparam int CW = LW + 1;
  localparam logic [CW-1:0] WORDS_C  = CW'(WORDS);
  localparam logic [CW-1:0] LAST_C   = CW'(WORDS - 1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [AW-1:0] OFF_MASK = AW'(2 * WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]   recv_cnt_q, recv_cnt_d;
  logic [AW-1:0]   base_q, base_d;

  always_comb begin
    state_d          = state_q;
    issue_cnt_d      = issue_cnt_q;
    recv_cnt_d       = recv_cnt_q;
    base_d           = base_q;
    fsm_busy         = miss_detected;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word        = '0;
    write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d     = FILL;
          base_d      = miss_address & ~OFF_MASK;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
        end
      end
      FILL: begin
        fsm_busy       = 1'b1;
        mem_read_en    = (issue_cnt_q < WORDS_C);
        memory_address = base_q + (AW'(issue_cnt_q) << 1);
        if (mem_read_en) begin
          issue_cnt_d = issue_cnt_q + ONE_C;
        end
        // Writes advance only on returned data, so memory stalls are absorbed.
        if (memory_data_valid && (recv_cnt_q < WORDS_C)) begin
          write_data_array = 1'b1;
          fill_word        = recv_cnt_q[LW-1:0];
          recv_cnt_d       = recv_cnt_q + ONE_C;
          if (recv_cnt_q == LAST_C) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      base_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      base_q      <= base_d;
    end
  end

  assign fill_data       = memory_data;
  assign fill_block_addr = base_q;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a 4-cycle pipelined memory model
// and a manual valid mode for stall and spurious-valid scenarios.
module tb_cache_fill_fsm;

  localparam logic [15:0] KEY = 16'hA5A5;

  logic        clk;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        write_tag_array;
  logic [15:0] fill_block_addr;

  int vectors;
  int miscompares;

  logic        mem_auto;
  logic        man_valid;
  logic [15:0] man_data;
  logic [3:0]  pipe_v;
  logic [15:0] pipe_a [4];

  cache_fill_fsm #(.WORDS(8), .AW(16), .DW(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_word         (fill_word),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array),
    .fill_block_addr   (fill_block_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference memory: a request captured at an edge returns four cycles later.
  initial pipe_v = 4'b0000;
  always @(posedge clk) begin
    pipe_v    <= {pipe_v[2:0], mem_read_en};
    pipe_a[0] <= memory_address;
    pipe_a[1] <= pipe_a[0];
    pipe_a[2] <= pipe_a[1];
    pipe_a[3] <= pipe_a[2];
  end

  assign memory_data_valid = mem_auto ? pipe_v[3] : man_valid;
  assign memory_data       = mem_auto ? (pipe_a[3] ^ KEY) : man_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic miss, input logic [15:0] addr);
    miss_detected = miss;
    miss_address  = addr;
  endtask

  // Full fill against the pipelined memory; cycle 0 is the current cycle.
  task automatic runFill(input logic [15:0] addr, input logic [15:0] base,
                         input logic next_miss, input logic [15:0] next_addr);
    applyStimulus(1'b1, addr);
    #1;
    checkOutput("busy_c0", 16'(fsm_busy), 16'd1);
    checkOutput("rd_c0", 16'(mem_read_en), 16'd0);
    checkOutput("wr_c0", 16'(write_data_array), 16'd0);
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 3) miss_address = 16'hBEEF;
      if (c == 13) applyStimulus(next_miss, next_addr);
      #1;
      checkOutput("busy", 16'(fsm_busy), 16'((c <= 12) || next_miss));
      checkOutput("rd_en", 16'(mem_read_en), 16'(c <= 8));
      if (c <= 8)
        checkOutput("req_addr", memory_address, base + 16'(2 * (c - 1)));
      if (c == 13)
        checkOutput("idle_addr", memory_address, 16'h0000);
      checkOutput("wr", 16'(write_data_array), 16'((c >= 5) && (c <= 12)));
      if ((c >= 5) && (c <= 12)) begin
        checkOutput("fill_word", 16'(fill_word), 16'(c - 5));
        checkOutput("fill_data", fill_data, (base + 16'(2 * (c - 5))) ^ KEY);
      end
      checkOutput("tag", 16'(write_tag_array), 16'(c == 12));
      if (c == 12)
        checkOutput("block_addr", fill_block_addr, base);
    end
  endtask

  initial begin
    bit vpat [11];
    int nexp;
    logic exp_wr;

    vectors     = 0;
    miscompares = 0;
    mem_auto    = 1'b1;
    man_valid   = 1'b0;
    man_data    = 16'h0000;
    rst         = 1'b1;
    applyStimulus(1'b0, 16'h0000);

    tick();
    tick();
    checkOutput("rst_busy", 16'(fsm_busy), 16'd0);
    checkOutput("rst_rd", 16'(mem_read_en), 16'd0);
    checkOutput("rst_addr", memory_address, 16'h0000);
    checkOutput("rst_wr", 16'(write_data_array), 16'd0);
    checkOutput("rst_tag", 16'(write_tag_array), 16'd0);
    checkOutput("rst_word", 16'(fill_word), 16'd0);
    checkOutput("rst_blk", fill_block_addr, 16'h0000);
    rst = 1'b0;

    $display("[TB] single fill at 0x1236");
    tick();
    runFill(16'h1236, 16'h1230, 1'b0, 16'h0000);

    $display("[TB] memory bubbles after word 2");
    tick();
    tick();
    mem_auto = 1'b0;
    vpat = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    nexp = 0;
    applyStimulus(1'b1, 16'h2468);
    #1;
    checkOutput("bub_busy_c0", 16'(fsm_busy), 16'd1);
    for (int c = 0; c < 11; c++) begin
      tick();
      man_valid = vpat[c];
      man_data  = 16'h5000 + 16'(c);
      #1;
      exp_wr = vpat[c] && (nexp < 8);
      checkOutput("bub_busy", 16'(fsm_busy), 16'd1);
      checkOutput("bub_wr", 16'(write_data_array), 16'(exp_wr));
      if (exp_wr) begin
        checkOutput("bub_word", 16'(fill_word), 16'(nexp));
        checkOutput("bub_data", fill_data, 16'h5000 + 16'(c));
      end
      checkOutput("bub_tag", 16'(write_tag_array), 16'(exp_wr && (nexp == 7)));
      if (exp_wr) nexp++;
    end
    tick();
    man_valid = 1'b0;
    applyStimulus(1'b0, 16'h0000);
    #1;
    checkOutput("bub_done_busy", 16'(fsm_busy), 16'd0);
    checkOutput("bub_blk", fill_block_addr, 16'h2460);

    $display("[TB] spurious valid in IDLE");
    tick();
    man_valid = 1'b1;
    man_data  = 16'h7777;
    #1;
    checkOutput("spur_wr", 16'(write_data_array), 16'd0);
    checkOutput("spur_tag", 16'(write_tag_array), 16'd0);
    checkOutput("spur_busy", 16'(fsm_busy), 16'd0);
    checkOutput("spur_data", fill_data, 16'h7777);
    tick();
    #1;
    checkOutput("spur_rd", 16'(mem_read_en), 16'd0);
    checkOutput("spur_wr2", 16'(write_data_array), 16'd0);
    man_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    mem_auto = 1'b1;

    $display("[TB] reset mid-fill");
    applyStimulus(1'b1, 16'h3456);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 7) begin
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0000);
      end
      if (c == 8) rst = 1'b0;
      #1;
      if (c == 8) begin
        checkOutput("mrst_rd", 16'(mem_read_en), 16'd0);
        checkOutput("mrst_addr", memory_address, 16'h0000);
        checkOutput("mrst_word", 16'(fill_word), 16'd0);
        checkOutput("mrst_blk", fill_block_addr, 16'h0000);
      end
      if (c >= 8) begin
        checkOutput("mrst_busy", 16'(fsm_busy), 16'd0);
        checkOutput("mrst_wr", 16'(write_data_array), 16'd0);
        checkOutput("mrst_tag", 16'(write_tag_array), 16'd0);
      end
    end
    tick();
    runFill(16'h3456, 16'h3450, 1'b0, 16'h0000);

    $display("[TB] wrap boundary at 0xFFFA");
    tick();
    runFill(16'hFFFA, 16'hFFF0, 1'b0, 16'h0000);

    $display("[TB] back-to-back misses");
    tick();
    runFill(16'h0040, 16'h0040, 1'b1, 16'h0080);
    runFill(16'h0080, 16'h0080, 1'b0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
